// File: rtl/tensor_agu.sv
// tensor_agu: tensor address generation unit.
// Walks an NDIM-deep loop nest (dimension 0 innermost). It emits one
// registered bank address per valid/ready transfer and pulses done after
// the final transfer.
// Optional feature macro: TENSOR_AGU_LAST_EN adds the addr_last output.
// addr_last flags the last element of each loop level.
module tensor_agu #(
    parameter int NDIM   = 3,
    parameter int BADDR  = 14,
    parameter int BSIZE  = 8,
    parameter int BSHIFT = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BADDR-1:0]        cfg_base,
    input  logic [NDIM*BSIZE-1:0]   cfg_size,
    input  logic [NDIM*BSHIFT-1:0]  cfg_shift,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic [BADDR-1:0]        addr
`ifdef TENSOR_AGU_LAST_EN
    ,
    output logic [NDIM-1:0]         addr_last
`endif
);

    // Wide enough that base plus every shifted index never overflows
    // before the final truncation to BADDR.
    localparam int WIDE = BADDR + BSIZE + (1 << BSHIFT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state;
    state_t                         state_nxt;

    logic [BADDR-1:0]               base_q;
    logic [NDIM-1:0][BSIZE-1:0]     size_q;
    logic [NDIM-1:0][BSHIFT-1:0]    shift_q;
    logic [NDIM-1:0][BSIZE-1:0]     idx;
    logic [NDIM-1:0][BSIZE-1:0]     idx_nxt;
    logic                           all_last;
    logic                           carry;
    logic                           xfer;
    logic                           launch;
    logic                           finish;
    logic                           stop;

    // Address of a given index vector: base + sum(idx[d] << shift[d]),
    // wrapping naturally modulo 2^BADDR.
    function automatic logic [BADDR-1:0] calc_addr(
        input logic [BADDR-1:0]            b,
        input logic [NDIM-1:0][BSIZE-1:0]  ix,
        input logic [NDIM-1:0][BSHIFT-1:0] sh
    );
        logic [WIDE-1:0] acc;
        acc = WIDE'(b);
        for (int d = 0; d < NDIM; d++) begin
            acc = acc + (WIDE'(ix[d]) << sh[d]);
        end
        return acc[BADDR-1:0];
    endfunction

`ifdef TENSOR_AGU_LAST_EN
    // Bit d is set when every dimension k <= d sits at its final index.
    function automatic logic [NDIM-1:0] calc_last(
        input logic [NDIM-1:0][BSIZE-1:0] ix,
        input logic [NDIM-1:0][BSIZE-1:0] sz
    );
        logic [NDIM-1:0] l;
        logic            run_and;
        run_and = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            run_and = run_and & (ix[d] == sz[d]);
            l[d]    = run_and;
        end
        return l;
    endfunction
`endif

    assign xfer = addr_valid && addr_ready;
    assign busy = (state != IDLE);

    // Odometer: next index vector after a transfer, plus final-element detect.
    always_comb begin
        idx_nxt  = idx;
        carry    = 1'b1;
        all_last = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            if (idx[d] != size_q[d]) begin
                all_last = 1'b0;
            end
            if (carry) begin
                if (idx[d] == size_q[d]) begin
                    idx_nxt[d] = '0;
                end else begin
                    idx_nxt[d] = idx[d] + 1'b1;
                    carry      = 1'b0;
                end
            end
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        stop      = 1'b0;
        case (state)
            IDLE: begin
                // start takes priority over a simultaneous abort here
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A final transfer completes the walk even if abort is also high.
                if (xfer && all_last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (abort) begin
                    stop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Config latch, index counters and registered address output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            size_q     <= '0;
            shift_q    <= '0;
            idx        <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                base_q     <= cfg_base;
                size_q     <= cfg_size;
                shift_q    <= cfg_shift;
                idx        <= '0;
                addr       <= cfg_base;
                addr_valid <= 1'b1;
            end else if (finish || stop) begin
                idx        <= '0;
                addr_valid <= 1'b0;
                done       <= finish;
            end else if (xfer) begin
                idx  <= idx_nxt;
                addr <= calc_addr(base_q, idx_nxt, shift_q);
            end
        end
    end

`ifdef TENSOR_AGU_LAST_EN
    // Per-level last-element flags, updated in lockstep with addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_last <= '0;
        end else if (launch) begin
            addr_last <= calc_last('0, cfg_size);
        end else if (finish || stop) begin
            addr_last <= '0;
        end else if (xfer) begin
            addr_last <= calc_last(idx_nxt, size_q);
        end
    end
`endif

endmodule

// File: doc/tensor_agu.md
Name: tensor_agu

Overview:
- Parametrised tensor address generation unit; one instance per MVU per tensor stream (weights, data, input, output).
- Replaces the fixed single-point base + (index << stride) computation with a sequencing engine.
- Walks an NDIM-deep nested loop nest and emits one bank address per valid/ready handshake toward the bank arbiter.
- Signals completion so the MVU sequencer can chain tensor operations.

Parameters:
- NDIM, 3: number of loop dimensions; dimension 0 is innermost.
- BADDR, 14: bitwidth of the emitted bank address.
- BSIZE, 8: bitwidth of each per-dimension size field.
- BSHIFT, 5: bitwidth of each per-dimension log2 stride field.

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: launch request; sampled only in IDLE.
- cfg_base, input, BADDR: tensor base address.
- cfg_size, input, NDIM*BSIZE: per-dimension iteration count minus one; dimension d occupies [d*BSIZE +: BSIZE].
- cfg_shift, input, NDIM*BSHIFT: per-dimension log2 stride; dimension d occupies [d*BSHIFT +: BSHIFT].
- abort, input, 1: synchronous cancel of the current walk.
- busy, output, 1: high when not in IDLE.
- done, output, 1: one-cycle pulse after the final address handshake.
- addr_valid, output, 1: addr holds a valid address.
- addr_ready, input, 1: consumer/arbiter grant.
- addr, output, BADDR: generated address.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, addr_valid=0, addr=0; all index counters=0; config registers=0.
- States: IDLE, RUN.
- IDLE + start=1:
  - Latch cfg_base, cfg_size, cfg_shift into internal registers; zero all indices.
  - Enter RUN; next cycle addr_valid=1 and addr=base. Latency start->first valid is 1 cycle.
  - cfg_* are don't-care after the start cycle.
- RUN, address function: addr = (base + sum over d of (idx[d] << shift[d])) mod 2^BADDR.
  - Compute at width BADDR+BSIZE+2^BSHIFT, then truncate to BADDR; wrap is natural and no flag is raised.
  - Register addr; no combinational path from any input to addr or addr_valid.
- Handshake:
  - A transfer occurs on a cycle with addr_valid && addr_ready.
  - With addr_valid=1 and addr_ready=0, addr and addr_valid hold stable.
  - addr_valid never drops without a transfer, except on abort or reset.
- Index advance on each transfer (odometer):
  - idx[0] increments.
  - When idx[d]==size[d], idx[d] wraps to 0 and idx[d+1] increments.
- Final transfer (every idx[d]==size[d]):
  - Next cycle: addr_valid=0, done=1 for exactly one cycle, state=IDLE, busy=0.
  - A start in that same done cycle is accepted.
- Throughput: one address per cycle while addr_ready is held high; no bubbles at dimension rollovers.
- Total transfers per walk = product of (size[d]+1). All-zero sizes give exactly one address (base).
- start while busy: ignored; no re-latch, no effect on the walk.
- abort in RUN:
  - Next cycle: IDLE, addr_valid=0, no done pulse, indices zeroed.
  - abort on a transfer cycle: that transfer counts, then the walk stops.
  - abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins.
- Reset mid-walk: immediate return to the reset values above; no done pulse.

Optional Feature:
- Macro: TENSOR_AGU_LAST_EN.
- Defined:
  - Adds output port addr_last, width NDIM, registered alongside addr.
  - addr_last[d]=1 when idx[k]==size[k] for all k<=d.
  - Marks the last element of each loop level, for the accumulator shift / max-pool clear sequencing.
  - Holds with addr under backpressure; 0 at reset and in IDLE.
- Undefined: the port is absent and the comparison logic is not generated; all other behaviour is identical.

Test Plan:
- Basic walk (NDIM=3):
  - Stimulus: base=0x100, size0=2, size1=1, size2=0, shift0=0, shift1=4, addr_ready=1.
  - Expect: addr 0x100,0x101,0x102,0x110,0x111,0x112 on consecutive cycles, first valid 1 cycle after start, then done pulse, busy=0.
- Backpressure:
  - Stimulus: same config; addr_ready held low 3 cycles at the second address.
  - Expect: addr stays 0x101 with addr_valid=1 across the stall; the sequence resumes intact; 6 transfers total.
- Wrap-around:
  - Stimulus: base=0x3FFE, size0=3, others 0, shift0=0.
  - Expect: 0x3FFE,0x3FFF,0x0000,0x0001, then done.
- Abort and ignored start:
  - Stimulus: start a 6-address walk; assert start again at transfer 2 (ignored); assert abort at transfer 4.
  - Expect: 4 transfers, addr_valid=0 next cycle, no done, busy=0; a fresh start then restarts at base.
- Reset mid-walk and minimal walk:
  - Stimulus: deassert rst_n during RUN; then start with all sizes 0.
  - Expect: all outputs 0 immediately on reset; then exactly one address = base, followed by done.
  - With TENSOR_AGU_LAST_EN: addr_last=3'b111 on that single address.
